// File: rtl/debug_pkg.sv
// Shared definitions for the data-memory debug dump path: FSM encodings,
// UART framing constants and a byte-lane helper.
package debug_pkg;

  localparam int UART_FRAME_BITS      = 10;
  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND
  } dumpState_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } txState_e;

  function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte serializer. A new byte offered during the last stop-bit cycle
// is accepted immediately, so consecutive frames have no idle gap.
module uart_tx_byte
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       txd,
  output logic       byteReady
);

  localparam int                CNT_W         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_DATA_BIT = 3'(UART_FRAME_BITS - 3);

  txState_e         state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             baudDone;

  assign baudDone = (baud_q == BAUD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // The baud counter wraps exactly when a bit ends, which is also the only
  // moment a bit transition happens, so every bit is CLKS_PER_BIT wide.
  always_comb begin
    state_d  = state_q;
    baud_d   = baudDone ? '0 : baud_q + 1'b1;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (byteValid) begin
          state_d  = START_BIT;
          shift_d  = byteData;
          bitCnt_d = '0;
        end
      end
      START_BIT: begin
        if (baudDone) begin
          state_d  = DATA_BITS;
          bitCnt_d = '0;
        end
      end
      DATA_BITS: begin
        if (baudDone) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitCnt_q == LAST_DATA_BIT) begin
            state_d = STOP_BIT;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (baudDone) begin
          if (byteValid) begin
            state_d  = START_BIT;
            shift_d  = byteData;
            bitCnt_d = '0;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txd is registered from the next-state view so the pin never glitches.
  always_comb begin
    byteReady = (state_q == TX_IDLE) || ((state_q == STOP_BIT) && baudDone);
    unique case (state_d)
      START_BIT: txd_d = 1'b0;
      DATA_BITS: txd_d = shift_d[0];
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;

endmodule

// File: rtl/mem_dump_tx.sv
// Debug readout engine: sweeps the data RAM through a spare read port and
// streams every word out of the board TX pin as four UART bytes, LSB first.
module mem_dump_tx
  import debug_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int WORDS        = 256,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [31:0]           memReadData,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam logic [1:0]            LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  dumpState_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            byteIdx_q, byteIdx_d;
  logic                  byteValid;
  logic [7:0]            byteData;
  logic                  byteReady;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clock    (clock),
    .reset    (reset),
    .byteValid(byteValid),
    .byteData (byteData),
    .txd      (txd),
    .byteReady(byteReady)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      byteIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      byteIdx_q <= byteIdx_d;
    end
  end

  // In SEND, byteReady only rises at the end of a stop bit; that is where the
  // next byte, the next word, or the end of the dump is decided.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    byteIdx_d = byteIdx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        word_d    = memReadData;
        byteIdx_d = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (byteReady) begin
          if (byteIdx_q != LAST_BYTE) begin
            byteIdx_d = byteIdx_q + 2'd1;
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte 0 goes straight from the RAM port so its start bit follows CAPTURE
  // without an extra cycle; later bytes come from the latched word.
  always_comb begin
    byteValid = (state_q == CAPTURE) || ((state_q == SEND) && (byteIdx_q != LAST_BYTE));
    byteData  = (state_q == CAPTURE) ? memReadData[7:0]
                                     : wordByte(word_q, byteIdx_q + 2'd1);
    busy      = (state_q != IDLE);
    done      = (state_q == SEND) && byteReady && (byteIdx_q == LAST_BYTE)
                && (addr_q == LAST_ADDR);
  end

  assign memAddr = addr_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: a UART receiver and a done monitor check
// the DUT output stream against bytes and done times queued by the stimulus.
module tb_mem_dump_tx;

  localparam int ADDR_WIDTH   = 3;
  localparam int WORDS        = 8;
  localparam int CLKS_PER_BIT = 4;
  localparam int DUMP_CYCLES  = 1296;  // 8 words * (2 + 40*4)

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [31:0]           memReadData;
  logic                  txd;
  logic                  busy;
  logic                  done;

  logic [31:0] mem [WORDS] = '{32'h12345678, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0000FF01,
                               32'h04040404, 32'h05050505, 32'h06060606, 32'h07070707};
  logic [7:0]  expBytes [32] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00,
                                 8'h04, 8'h04, 8'h04, 8'h04, 8'h05, 8'h05, 8'h05, 8'h05,
                                 8'h06, 8'h06, 8'h06, 8'h06, 8'h07, 8'h07, 8'h07, 8'h07};

  logic [7:0] expQ [$];
  int         doneQ [$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         lastStart = 0;
  int         lastDone = 0;

  mem_dump_tx #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WORDS       (WORDS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .memAddr    (memAddr),
    .memReadData(memReadData),
    .txd        (txd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) memReadData <= mem[memAddr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives a one-cycle start; when a dump is expected, queues its bytes and done time.
  task automatic applyStimulus(input bit expectDump);
    start = 1'b1;
    if (expectDump) begin
      foreach (expBytes[i]) expQ.push_back(expBytes[i]);
      lastStart = cyc;
      lastDone  = cyc + DUMP_CYCLES;
      doneQ.push_back(lastDone);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // UART receiver: each bit must stay constant for CLKS_PER_BIT samples.
  bit         rxActive = 1'b0;
  int         rxCnt = 0;
  logic [9:0] rxBits = '1;
  bit         rxBitOk = 1'b1;

  always @(negedge clock) begin
    if (!reset) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (txd === 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 1;
        rxBits   = '1;
        rxBits[0] = 1'b0;
        rxBitOk  = 1'b1;
      end
    end else begin
      if (rxCnt % CLKS_PER_BIT == 0) rxBits[4'(rxCnt / CLKS_PER_BIT)] = txd;
      else if (txd !== rxBits[4'(rxCnt / CLKS_PER_BIT)]) rxBitOk = 1'b0;
      rxCnt++;
      if (rxCnt == 10 * CLKS_PER_BIT) begin
        rxActive = 1'b0;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected byte: got 0x%0h, expected no byte", rxBits[8:1]);
        end else begin
          checkOutput("rx byte", 32'(rxBits[8:1]), 32'(expQ.pop_front()));
          checkOutput("rx framing", {29'd0, rxBits[9], rxBits[0], rxBitOk}, 32'b101);
        end
      end
    end
  end

  bit busyCheckPending = 1'b0;

  always @(negedge clock) begin
    if (busyCheckPending) begin
      checkOutput("busy after done", 32'(busy), 32'd0);
      busyCheckPending = 1'b0;
    end
    if (done === 1'b1) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected done", 32'(done), 32'd0);
      end else begin
        checkOutput("done cycle", cyc, doneQ.pop_front());
        checkOutput("addr at done", 32'(memAddr), 32'd7);
        checkOutput("busy at done", 32'(busy), 32'd1);
        busyCheckPending = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkOutput("reset txd", 32'(txd), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset memAddr", 32'(memAddr), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      repeat (10) @(posedge clock);
      @(negedge clock);
      checkOutput("idle outputs", {26'd0, txd, busy, done, memAddr}, 32'b100000);
    end
    @(posedge clock);
    #1;

    // Dump 1 with stray starts mid-byte and on the done cycle, then a restart.
    applyStimulus(1'b1);
    waitUntil(lastStart + 50);
    applyStimulus(1'b0);
    waitUntil(lastDone);
    start = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(1'b1);

    // Dump 2 is cut by reset during bit 1 of byte 2 of word 1 (0xA5 -> bit is 0).
    waitUntil(lastStart + 254);
    checkOutput("txd before reset", 32'(txd), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset txd", 32'(txd), 32'd1);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    checkOutput("async reset memAddr", 32'(memAddr), 32'd0);
    expQ.delete();
    doneQ.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Dump 3 must start again from address 0.
    applyStimulus(1'b1);
    waitUntil(lastDone + 3);
    @(negedge clock);
    checkOutput("idle memAddr held", 32'(memAddr), 32'd7);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle txd", 32'(txd), 32'd1);
    checkOutput("bytes outstanding", expQ.size(), 32'd0);
    checkOutput("done outstanding", doneQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
Debug readout engine for the data RAM that the pipeline writes through its store path. On a start pulse it sweeps data-memory addresses 0..WORDS-1 through a synchronous read port with 1-cycle latency. It serializes each 32-bit word as four UART 8N1 bytes, least significant byte first. It sits beside the data RAM on a second read port, so the datapath is untouched, and feeds the board TX pin.

Parameters:
ADDR_WIDTH, 8, width of the data-memory word address.
WORDS, 256, number of words dumped; legal range is 1..2^ADDR_WIDTH.
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  1-cycle request to begin a dump; sampled only in IDLE.
memAddr  out  ADDR_WIDTH  read address to the data RAM read port; registered.
memReadData  in  32  RAM read data, valid one cycle after memAddr is presented.
txd  out  1  UART serial output; idle level is 1.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  1-cycle pulse when the last stop bit of the last word completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, txd=1, busy=0, done=0, memAddr=0, byte index=0, baud counter=0, shift register=0.
- FSM states: IDLE, FETCH, CAPTURE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE with start=1: memAddr<=0, busy<=1, go to FETCH.
- IDLE with start=0: hold. A start pulse outside IDLE is ignored and is not queued.
- FETCH: hold memAddr for exactly 1 cycle, then go to CAPTURE.
- CAPTURE: latch memReadData into a 32-bit word register, set byte index=0, load byte word[7:0], go to START_BIT.
- START_BIT: txd=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter runs 0..7.
- STOP_BIT: txd=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - byte index<3: increment the index, load word[8*idx+7:8*idx], go to START_BIT (no idle gap between bytes).
  - byte index=3 and memAddr<WORDS-1: memAddr<=memAddr+1, go to FETCH.
  - byte index=3 and memAddr=WORDS-1: done=1 for one cycle, busy<=0, go to IDLE. memAddr keeps its value until the next start.
- memAddr never exceeds WORDS-1 and never wraps. With WORDS=2^ADDR_WIDTH the final address is all ones, with no overflow.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every bit transition, so every bit lasts exactly CLKS_PER_BIT cycles.
- txd is driven from a register, so it is glitch-free.
- Timing per word: 2 cycles (FETCH + CAPTURE) + 40*CLKS_PER_BIT.
- Full dump time: done asserts WORDS*(2+40*CLKS_PER_BIT) cycles after the cycle in which start is accepted.
- start in the same cycle as done: done occurs in the last non-IDLE cycle, so that start is ignored. A start in the following cycle is accepted.
- Reset mid-operation: txd returns to 1 immediately (asynchronous). The partial frame is abandoned, and the next start restarts from address 0.
- memReadData is sampled only in CAPTURE. RAM writes by the pipeline during a dump are not this block's concern.

Decomposition:
- Shared package (debug_pkg): FSM state encoding, UART_FRAME_BITS=10, BYTES_PER_WORD=4, default CLKS_PER_BIT.
- Sub-module uart_tx_byte: one 8N1 byte serializer with a baud counter.
  - Inputs: clock, reset, byteValid, byteData[7:0].
  - Outputs: txd, byteReady.
  - The parent FSM owns the fetch/capture and byte-index sequencing. START_BIT/DATA_BITS/STOP_BIT live inside uart_tx_byte.

Test Plan:
- Reset: hold reset=0 and toggle clock -> txd=1, busy=0, done=0, memAddr=0. Release reset with no start -> outputs unchanged for 100 cycles.
- Single word: CLKS_PER_BIT=4, WORDS=1, mem[0]=0x12345678, pulse start.
  - Bytes decoded on txd are 0x78, 0x56, 0x34, 0x12, each a start 0 + 8 LSB-first bits + stop 1, with every bit 4 cycles wide.
  - done pulses exactly 162 cycles after start is accepted; busy falls with it.
- Multi word: WORDS=4, mem = 0x00000000, 0xFFFFFFFF, 0xA5A5A5A5, 0x0000FF01.
  - Received stream is 16 bytes: 00 00 00 00 FF FF FF FF A5 A5 A5 A5 01 FF 00 00.
  - memAddr steps 0,1,2,3 and never shows 4; exactly one done pulse.
- Start while busy: pulse start again mid-byte and on the done cycle -> no restart, identical byte stream, single done. A start one cycle after done begins a new dump from address 0.
- Reset mid-frame: assert reset during DATA_BITS of byte 2 of word 1 -> txd=1 asynchronously, busy=0. A new start yields a full dump beginning with mem[0]'s byte 0.
- Full range: ADDR_WIDTH=3, WORDS=8, mem[i]=i*0x01010101 -> 32 bytes in address order; memAddr ends at 7 with no wrap to 0 before done.
